// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant held until done_i, rotating priority after each release.
// Define RR_ARBITER_TIMEOUT_EN to compile in a grant watchdog that forces release after TIMEOUT cycles.
module rr_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic [WIDTH-1:0]         req_i,
    input  logic                     done_i,
    output logic [WIDTH-1:0]         gnt_o,
    output logic                     gnt_val_o,
    output logic [$clog2(WIDTH)-1:0] gnt_idx_o,
    output logic                     timeout_o
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    gntIdx_q, gntIdx_d;
    logic [IW-1:0]    lastIdx_q, lastIdx_d;

    logic [IW-1:0]    selIdx;
    logic [IW-1:0]    lowAll;
    logic [IW-1:0]    lowAbove;
    logic             foundAll;
    logic             foundAbove;
    logic             newGrant;
    logic             relGrant;
    logic             forceRel;

    // Lowest requester strictly above the last winner, otherwise wrap to the lowest requester.
    always_comb begin
        lowAll     = '0;
        lowAbove   = '0;
        foundAll   = 1'b0;
        foundAbove = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (req_i[k] && !foundAll) begin
                lowAll   = IW'(k);
                foundAll = 1'b1;
            end
            if (req_i[k] && !foundAbove && (k > int'(lastIdx_q))) begin
                lowAbove   = IW'(k);
                foundAbove = 1'b1;
            end
        end
        selIdx = foundAbove ? lowAbove : lowAll;
    end

    assign relGrant = (state_q == BUSY) && (done_i || forceRel);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gntIdx_d  = gntIdx_q;
        lastIdx_d = lastIdx_q;
        newGrant  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    newGrant = 1'b1;
                end
            end
            BUSY: begin
                if (relGrant) begin
                    if (|req_i) begin
                        newGrant = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        gntIdx_d = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gntIdx_d = '0;
            end
        endcase
        // A release with pending requests hands over in the same edge, so there is no idle gap.
        if (newGrant) begin
            state_d   = BUSY;
            gnt_d     = {{(WIDTH-1){1'b0}}, 1'b1} << selIdx;
            gntIdx_d  = selIdx;
            lastIdx_d = selIdx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gntIdx_q  <= '0;
            lastIdx_q <= IW'(WIDTH - 1);
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gntIdx_q  <= gntIdx_d;
            lastIdx_q <= lastIdx_d;
        end
    end

`ifdef RR_ARBITER_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] holdCnt_q, holdCnt_d;
    logic          timeout_q, timeout_d;

    // A done_i landing on the last allowed cycle counts as a normal release, hence the !done_i.
    assign forceRel = (state_q == BUSY) && (holdCnt_q == CW'(TIMEOUT - 1)) && !done_i;

    always_comb begin
        holdCnt_d = holdCnt_q;
        timeout_d = forceRel;
        if (newGrant) begin
            holdCnt_d = '0;
        end else if ((state_q == BUSY) && !relGrant) begin
            holdCnt_d = holdCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            holdCnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            holdCnt_q <= holdCnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign forceRel  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign gnt_o     = gnt_q;
    assign gnt_idx_o = gntIdx_q;
    assign gnt_val_o = |gnt_q;

`ifndef SYNTHESIS
    // Grant must stay one-hot and its index must always encode the set bit.
    gntOneHot: assert property (@(posedge clk_i) disable iff (srst_i) $onehot0(gnt_o));
    gntIdxMatch: assert property (@(posedge clk_i) disable iff (srst_i)
        gnt_val_o |-> (gnt_o == ({{(WIDTH-1){1'b0}}, 1'b1} << gnt_idx_o)));
    idleIdxZero: assert property (@(posedge clk_i) disable iff (srst_i)
        !gnt_val_o |-> (gnt_idx_o == '0));
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter (WIDTH=4, TIMEOUT=8): directed vectors, literal checkpoints and a per-cycle reference model.
// Build with or without RR_ARBITER_TIMEOUT_EN; the model and checkpoints follow the same macro.
module tb_rr_arbiter;

    localparam int W  = 4;
    localparam int TO = 8;
`ifdef RR_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         srst;
    logic [W-1:0] req;
    logic         done;
    logic [W-1:0] gnt;
    logic         gntVal;
    logic [1:0]   gntIdx;
    logic         timeoutPulse;

    int assertCount = 0;
    int failCount   = 0;
    bit checkEn     = 1'b0;

    int expGnt  = -1;
    int expLast = W - 1;
    int expHeld = 0;
    bit expTo   = 1'b0;

    rr_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_i     (clk),
        .srst_i    (srst),
        .req_i     (req),
        .done_i    (done),
        .gnt_o     (gnt),
        .gnt_val_o (gntVal),
        .gnt_idx_o (gntIdx),
        .timeout_o (timeoutPulse)
    );

    always #5 clk = ~clk;

    // Rotating search: walk indices last+1, last+2, ... modulo W and take the first requester.
    function automatic int pickNext(logic [W-1:0] r, int last);
        int k;
        for (int j = 1; j <= W; j++) begin
            k = (last + j) % W;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] vecOf(int g);
        logic [W-1:0] one;
        one = 4'b0001;
        return (g < 0) ? '0 : (one << g);
    endfunction

    always @(posedge clk) begin
        if (srst) begin
            expGnt  <= -1;
            expLast <= W - 1;
            expHeld <= 0;
            expTo   <= 1'b0;
        end else begin
            expTo <= 1'b0;
            if (expGnt < 0 || done || (TO_EN && expHeld >= TO)) begin
                if (expGnt >= 0 && !done && TO_EN && expHeld >= TO) expTo <= 1'b1;
                if (req != '0) begin
                    expGnt  <= pickNext(req, expLast);
                    expLast <= pickNext(req, expLast);
                    expHeld <= 1;
                end else begin
                    expGnt  <= -1;
                    expHeld <= 0;
                end
            end else begin
                expHeld <= expHeld + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [W-1:0] gntExp,
                               input logic [1:0] idxExp, input logic valExp, input logic toExp);
        assertCount++;
        if ({gnt, gntIdx, gntVal, timeoutPulse} !== {gntExp, idxExp, valExp, toExp}) begin
            failCount++;
            $display("[TB] FAIL %s: got gnt=%b idx=%0d val=%b to=%b, required gnt=%b idx=%0d val=%b to=%b",
                     name, gnt, gntIdx, gntVal, timeoutPulse, gntExp, idxExp, valExp, toExp);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model", vecOf(expGnt), (expGnt < 0) ? 2'd0 : 2'(expGnt),
                        expGnt >= 0, expTo);
            assertCount++;
            if (!$onehot0(gnt)) begin
                failCount++;
                $display("[TB] FAIL onehot: got gnt=%b, required at most one bit set", gnt);
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] r, input logic d, input logic s, input int cycles);
        req  = r;
        done = d;
        srst = s;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        srst = 1'b1;
        req  = '0;
        done = 1'b0;

        applyStimulus(4'b0000, 1'b0, 1'b1, 2);
        checkEn = 1'b1;
        checkOutput("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        applyStimulus(4'b1010, 1'b0, 1'b0, 1);
        checkOutput("first grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1);
        checkOutput("release to idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1);
        checkOutput("reset again", 4'b0000, 2'd0, 1'b0, 1'b0);

        applyStimulus(4'b1111, 1'b0, 1'b0, 1);
        checkOutput("rr grant 0", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(4'b1111, 1'b1, 1'b0, 1);
            checkOutput($sformatf("rr step %0d", i), vecOf(i % W), 2'(i % W), 1'b1, 1'b0);
        end
        applyStimulus(4'b1111, 1'b1, 1'b0, 3);
        checkOutput("rr reach 3", 4'b1000, 2'd3, 1'b1, 1'b0);

        applyStimulus(4'b1001, 1'b1, 1'b0, 1);
        checkOutput("wrap to 0", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(4'b1001, 1'b1, 1'b0, 1);
        checkOutput("skip to 3", 4'b1000, 2'd3, 1'b1, 1'b0);

        applyStimulus(4'b0100, 1'b1, 1'b0, 1);
        checkOutput("grant 2", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 5);
        checkOutput("hold after req drop", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1);
        checkOutput("done to idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 2);
        checkOutput("done ignored in idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        applyStimulus(4'b0001, 1'b0, 1'b0, 1);
        checkOutput("grant 0 after 2", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(4'b1111, 1'b1, 1'b1, 1);
        checkOutput("reset in busy", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b1100, 1'b0, 1'b0, 1);
        checkOutput("post-reset grant 2", 4'b0100, 2'd2, 1'b1, 1'b0);

        applyStimulus(4'b1100, 1'b0, 1'b0, 7);
        checkOutput("held 8 cycles", 4'b0100, 2'd2, 1'b1, 1'b0);
`ifdef RR_ARBITER_TIMEOUT_EN
        applyStimulus(4'b1100, 1'b0, 1'b0, 1);
        checkOutput("timeout moves grant", 4'b1000, 2'd3, 1'b1, 1'b1);
        applyStimulus(4'b1100, 1'b0, 1'b0, 1);
        checkOutput("timeout pulse ends", 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(4'b1100, 1'b0, 1'b0, 6);
        applyStimulus(4'b1100, 1'b1, 1'b0, 1);
        checkOutput("done at limit no pulse", 4'b0100, 2'd2, 1'b1, 1'b0);
`else
        applyStimulus(4'b1100, 1'b0, 1'b0, 1);
        checkOutput("no watchdog at 9", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b1100, 1'b0, 1'b0, 11);
        checkOutput("held at 20", 4'b0100, 2'd2, 1'b1, 1'b0);
`endif

        applyStimulus(4'b0000, 1'b1, 1'b0, 1);
        checkOutput("final idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 2);
        checkEn = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of stimulus, required finish before 100000 time units");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
